seg7_scan_driver: RTL

Time-multiplexed driver for the board's 8-digit common-anode 7-segment display. It sits directly downstream of the AXI-lite 7-segment register IP and consumes that IP's register contents: digit nibbles, digit-enable mask, decimal-point mask and a brightness code. It scans one digit at a time, hex-decodes the digit, applies PWM brightness and dead-time blanking, and drives active-low anode and segment pins. New register values are double-buffered and take effect only at a frame boundary, so a frame never shows a mix of old and new values.

---
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with PWM brightness,
// phase-0 dead time and frame-aligned double buffering of the display values.
module seg7_scan_driver #(
  parameter int PHASE_CYCLES = 781
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        upd,
  input  logic [31:0] digit_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_en,
  input  logic [3:0]  bright,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CYC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

  // Active-low hex font, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
      4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
      4'h8: f = 7'h00;  4'h9: f = 7'h10;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
      4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  default: f = 7'h0E;
    endcase
    return f;
  endfunction

  logic [CYC_W-1:0] r_cyc;
  logic [3:0]       r_phase;
  logic [2:0]       r_digit;

  logic [31:0] r_st_data, r_sh_data;
  logic [7:0]  r_st_en, r_sh_en;
  logic [7:0]  r_st_dp, r_sh_dp;
  logic [3:0]  r_st_bright, r_sh_bright;
  logic        r_pending;

  logic       w_cyc_wrap, w_phase_wrap, w_frame_wrap;
  logic       w_lit;
  logic [3:0] w_nib;
  logic [7:0] w_an_sel;

  assign w_cyc_wrap   = (r_cyc == CYC_W'(PHASE_CYCLES - 1));
  assign w_phase_wrap = w_cyc_wrap && (r_phase == 4'd15);
  assign w_frame_wrap = w_phase_wrap && (r_digit == 3'd7);

  // Scan counters: cyc -> phase -> digit; the digit wrap is the frame boundary.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cyc   <= '0;
      r_phase <= '0;
      r_digit <= '0;
    end else begin
      r_cyc <= w_cyc_wrap ? '0 : r_cyc + 1'b1;
      if (w_cyc_wrap) r_phase <= r_phase + 4'd1;
      if (w_phase_wrap) r_digit <= r_digit + 3'd1;
    end
  end

  // Staging and shadow: shadow only changes on the boundary edge, so a frame
  // never mixes old and new values. A coincident upd bypasses the staging copy.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_st_data   <= '0;
      r_st_en     <= '0;
      r_st_dp     <= '0;
      r_st_bright <= '0;
      r_sh_data   <= '0;
      r_sh_en     <= '0;
      r_sh_dp     <= '0;
      r_sh_bright <= '0;
      r_pending   <= 1'b0;
    end else if (w_frame_wrap) begin
      if (upd) begin
        r_sh_data   <= digit_data;
        r_sh_en     <= digit_en;
        r_sh_dp     <= dp_en;
        r_sh_bright <= bright;
      end else if (r_pending) begin
        r_sh_data   <= r_st_data;
        r_sh_en     <= r_st_en;
        r_sh_dp     <= r_st_dp;
        r_sh_bright <= r_st_bright;
      end
      r_pending <= 1'b0;
    end else if (upd) begin
      r_st_data   <= digit_data;
      r_st_en     <= digit_en;
      r_st_dp     <= dp_en;
      r_st_bright <= bright;
      r_pending   <= 1'b1;
    end
  end

  // Phase 0 of every slot is dark, giving dead time between anodes.
  assign w_lit    = r_sh_en[r_digit] && (r_phase != 4'd0) && (r_phase <= r_sh_bright);
  assign w_nib    = r_sh_data[{r_digit, 2'b00} +: 4];
  assign w_an_sel = ~(8'd1 << r_digit);

  // Output register stage: pins reflect the previous cycle's counter state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      an_n       <= 8'hFF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= w_lit ? w_an_sel : 8'hFF;
      seg_n      <= w_lit ? hex_font(w_nib) : 7'h7F;
      dp_n       <= w_lit ? ~r_sh_dp[r_digit] : 1'b1;
      frame_tick <= (r_digit == 3'd0) && (r_phase == 4'd0) && (r_cyc == '0);
    end
  end

endmodule
